// File: rtl/singlecycle_pkg.sv
// Shared types and constants for the memory port arbiter.
package singlecycle_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } ArbState_e;

  // Requester index assignment on the shared port.
  localparam int unsigned ARB_REQ_LSU = 0;
  localparam int unsigned ARB_REQ_IF  = 1;
  localparam int unsigned ARB_REQ_DBG = 2;

  // Timeout counter width; kept at least 1 bit so a disabled timeout still elaborates.
  function automatic int unsigned arb_cnt_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational one-hot request picker.
// Build option MEM_ARB_RR_EN: round-robin starting after i_last_grant;
// otherwise fixed priority with the lowest index winning.
module mem_arb_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_vld,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_REQ-1:0] o_gnt_oh,
  output logic [IDX_W-1:0]   o_gnt_idx
);

`ifdef MEM_ARB_RR_EN
  // Scan forward from the requester after the last winner, wrapping around.
  always_comb begin
    int unsigned cand;
    logic        found;
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(i_last_grant) + off) % NUM_REQ;
      if (!found && i_vld[cand]) begin
        found          = 1'b1;
        o_gnt_oh[cand] = 1'b1;
        o_gnt_idx      = IDX_W'(cand);
      end
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^i_last_grant;

  // Fixed priority: first valid requester from index 0 upward.
  always_comb begin
    logic found;
    o_gnt_oh  = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && i_vld[i]) begin
        found       = 1'b1;
        o_gnt_oh[i] = 1'b1;
        o_gnt_idx   = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one LSU/SRAM VALID/READY port between NUM_REQ requesters, one transaction
// at a time, with a timeout abort. Build option MEM_ARB_RR_EN selects round-robin
// arbitration (default: fixed priority, index 0 highest).
module mem_port_arbiter
  import singlecycle_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_REQ-1:0]      i_req_vld,
  input  logic [NUM_REQ-1:0][31:0] i_req_addr,
  input  logic [NUM_REQ-1:0][31:0] i_req_wdata,
  input  logic [NUM_REQ-1:0][3:0] i_req_strb,
  input  logic [NUM_REQ-1:0]      i_req_wren,
  output logic [NUM_REQ-1:0]      o_req_rdy,
  output logic [NUM_REQ-1:0]      o_rsp_vld,
  output logic [31:0]             o_rsp_rdata,
  output logic                    o_rsp_err,
  output logic                    o_mem_vld,
  output logic [31:0]             o_mem_addr,
  output logic [31:0]             o_mem_wdata,
  output logic [3:0]              o_mem_strb,
  output logic                    o_mem_wren,
  input  logic                    i_mem_rdy,
  input  logic [31:0]             i_mem_rdata,
  output logic                    o_busy
);

  localparam int unsigned CNT_W = arb_cnt_w(TIMEOUT_CYC);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CntLast = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(NUM_REQ - 1);

  ArbState_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic [3:0]       mem_strb_q, mem_strb_d;
  logic             mem_wren_q, mem_wren_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   last_grant;
  logic               accept;
  logic               timeout_hit;

  assign accept      = (state_q == ARB_IDLE) && (|i_req_vld);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CntLast);

`ifdef MEM_ARB_RR_EN
  logic [IDX_W-1:0] last_grant_q;

  // Remember the most recent winner; reset value makes requester 0 win first.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_grant_q <= IdxLast;
    end else if (accept) begin
      last_grant_q <= pick_idx;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = IdxLast;
`endif

  mem_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_vld        (i_req_vld),
    .i_last_grant (last_grant),
    .o_gnt_oh     (pick_oh),
    .o_gnt_idx    (pick_idx)
  );

  // Next-state: accept and latch in IDLE, wait/time out in BUSY, one-cycle response.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_idx_d   = gnt_idx_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_strb_d  = mem_strb_q;
    mem_wren_d  = mem_wren_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          gnt_idx_d   = pick_idx;
          mem_addr_d  = i_req_addr[pick_idx];
          mem_wdata_d = i_req_wdata[pick_idx];
          mem_strb_d  = i_req_strb[pick_idx];
          mem_wren_d  = i_req_wren[pick_idx];
          cnt_d       = '0;
          state_d     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Completion takes precedence over a coincident timeout.
        if (i_mem_rdy) begin
          rsp_rdata_d = mem_wren_q ? 32'h0 : i_mem_rdata;
          rsp_err_d   = 1'b0;
          state_d     = ARB_RESP;
        end else if (timeout_hit) begin
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          state_d     = ARB_RESP;
        end
      end
      ARB_RESP: begin
        cnt_d   = '0;
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and latched command/response registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= '0;
      gnt_idx_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_strb_q  <= '0;
      mem_wren_q  <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_idx_q   <= gnt_idx_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_strb_q  <= mem_strb_d;
      mem_wren_q  <= mem_wren_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Outputs decoded from the registered state; o_mem_vld falls with async reset.
  always_comb begin
    o_rsp_vld = '0;
    if (state_q == ARB_RESP) begin
      o_rsp_vld[gnt_idx_q] = 1'b1;
    end
    o_req_rdy   = (state_q == ARB_IDLE) ? pick_oh : '0;
    o_mem_vld   = (state_q == ARB_BUSY);
    o_busy      = (state_q != ARB_IDLE);
    o_mem_addr  = mem_addr_q;
    o_mem_wdata = mem_wdata_q;
    o_mem_strb  = mem_strb_q;
    o_mem_wren  = mem_wren_q;
    o_rsp_rdata = rsp_rdata_q;
    o_rsp_err   = rsp_err_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (NUM_REQ=3, TIMEOUT_CYC=8).
module tb_mem_port_arbiter;

  logic             clk;
  logic             rst_n;
  logic [2:0]       req_vld;
  logic [2:0][31:0] req_addr;
  logic [2:0][31:0] req_wdata;
  logic [2:0][3:0]  req_strb;
  logic [2:0]       req_wren;
  logic [2:0]       req_rdy;
  logic [2:0]       rsp_vld;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             mem_vld;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_strb;
  logic             mem_wren;
  logic             mem_rdy;
  logic [31:0]      mem_rdata;
  logic             busy;

  int n_run;
  int n_fail;

  mem_port_arbiter #(
    .NUM_REQ     (3),
    .TIMEOUT_CYC (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_vld   (req_vld),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .i_req_strb  (req_strb),
    .i_req_wren  (req_wren),
    .o_req_rdy   (req_rdy),
    .o_rsp_vld   (rsp_vld),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_mem_vld   (mem_vld),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_strb  (mem_strb),
    .o_mem_wren  (mem_wren),
    .i_mem_rdy   (mem_rdy),
    .i_mem_rdata (mem_rdata),
    .o_busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  vld;
    logic [1:0]  exp_idx;
    logic        wren;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          dly;
    logic [31:0] mem_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [2:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < 3; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    logic [2:0] exp_oh;
    exp_oh = 3'b001 << v.exp_idx;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (i == int'(v.exp_idx)) begin
        req_addr[i]  = v.addr;
        req_wdata[i] = v.wdata;
        req_strb[i]  = v.strb;
        req_wren[i]  = v.wren;
      end else begin
        req_addr[i]  = 32'hBAD0_0000 | 32'(i);
        req_wdata[i] = 32'hA5A5_0000 | 32'(i);
        req_strb[i]  = 4'hF;
        req_wren[i]  = ~v.wren;
      end
    end
    req_vld = v.vld;
    #1;
    chk($sformatf("v%0d req_rdy", id), 32'(req_rdy), 32'(exp_oh));
    @(negedge clk);
    req_vld = '0;
    chk($sformatf("v%0d mem_vld", id), 32'(mem_vld), 32'd1);
    chk($sformatf("v%0d mem_addr", id), mem_addr, v.addr);
    chk($sformatf("v%0d mem_wdata", id), mem_wdata, v.wdata);
    chk($sformatf("v%0d mem_strb", id), 32'(mem_strb), 32'(v.strb));
    chk($sformatf("v%0d mem_wren", id), 32'(mem_wren), 32'(v.wren));
    repeat (v.dly) @(negedge clk);
    chk($sformatf("v%0d mem_vld_hold", id), 32'(mem_vld), 32'd1);
    mem_rdy   = 1'b1;
    mem_rdata = v.mem_rdata;
    @(negedge clk);
    mem_rdy = 1'b0;
    #1;
    chk($sformatf("v%0d rsp_vld", id), 32'(rsp_vld), 32'(exp_oh));
    chk($sformatf("v%0d rsp_rdata", id), rsp_rdata, v.exp_rdata);
    chk($sformatf("v%0d rsp_err", id), 32'(rsp_err), 32'd0);
    chk($sformatf("v%0d mem_vld_drop", id), 32'(mem_vld), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d rsp_vld_pulse", id), 32'(rsp_vld), 32'd0);
    chk($sformatf("v%0d idle", id), 32'(busy), 32'd0);
  endtask

  initial begin
    int got[4];
    int exp_order[4];
    int n;
    int hi;

    n_run = 0;
    n_fail = 0;
    rst_n = 1'b0;
    req_vld = '0;
    req_addr = '0;
    req_wdata = '0;
    req_strb = '0;
    req_wren = '0;
    mem_rdy = 1'b0;
    mem_rdata = '0;

    //                vld     idx   wren  addr          wdata         strb    dly rdata        exp
    vecs[0] = '{3'b001, 2'd0, 1'b0, 32'h0000_0100, 32'h0,        4'hF,   2, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{3'b100, 2'd2, 1'b1, 32'h0000_7000, 32'h12345678, 4'b0011, 0, 32'hFFFFFFFF, 32'h0};
    vecs[2] = '{3'b010, 2'd1, 1'b0, 32'h2000_0004, 32'h0,        4'hF,   7, 32'h55AA55AA, 32'h55AA55AA};
`ifdef MEM_ARB_RR_EN
    vecs[3] = '{3'b110, 2'd2, 1'b0, 32'h0000_0208, 32'h0,        4'hF,   1, 32'h0BAD_F00D, 32'h0BAD_F00D};
`else
    vecs[3] = '{3'b110, 2'd1, 1'b0, 32'h0000_0208, 32'h0,        4'hF,   1, 32'h0BAD_F00D, 32'h0BAD_F00D};
`endif
    vecs[4] = '{3'b111, 2'd0, 1'b1, 32'h0000_0400, 32'hCAFE0001, 4'b1000, 3, 32'h1111_2222, 32'h0};
`ifdef MEM_ARB_RR_EN
    vecs[5] = '{3'b011, 2'd1, 1'b0, 32'h0000_0500, 32'h0,        4'hF,   0, 32'h7777_8888, 32'h7777_8888};
    exp_order = '{0, 1, 0, 1};
`else
    vecs[5] = '{3'b011, 2'd0, 1'b0, 32'h0000_0500, 32'h0,        4'hF,   0, 32'h7777_8888, 32'h7777_8888};
    exp_order = '{0, 0, 0, 0};
`endif

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst mem_vld", 32'(mem_vld), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rsp_vld", 32'(rsp_vld), 32'd0);
    chk("rst req_rdy", 32'(req_rdy), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // req0+req1 held for four back-to-back transactions
    @(negedge clk);
    req_vld = 3'b011;
    mem_rdy = 1'b1;
    mem_rdata = 32'h0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (|req_rdy) begin
        got[n] = oh2idx(req_rdy);
        n++;
      end
      if (n == 4) break;
      @(negedge clk);
    end
    chk("order count", 32'(n), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < n) chk($sformatf("order[%0d]", k), 32'(got[k]), 32'(exp_order[k]));
    end
    @(negedge clk);
    req_vld = '0;
    repeat (2) @(negedge clk);
    mem_rdy = 1'b0;
    chk("order idle", 32'(busy), 32'd0);

    for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

    // Timeout: no completion ever arrives
    @(negedge clk);
    req_addr[0] = 32'h0000_0300;
    req_wren[0] = 1'b0;
    req_vld = 3'b001;
    @(negedge clk);
    req_vld = '0;
    hi = 0;
    for (int c = 0; c < 30; c++) begin
      if (!mem_vld) break;
      hi++;
      @(negedge clk);
    end
    chk("tmo vld cycles", 32'(hi), 32'd8);
    chk("tmo rsp_vld", 32'(rsp_vld), 32'b001);
    chk("tmo rsp_err", 32'(rsp_err), 32'd1);
    chk("tmo rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    chk("tmo idle", 32'(busy), 32'd0);
    chk("tmo pulse", 32'(rsp_vld), 32'd0);

    // Reset asserted while BUSY
    @(negedge clk);
    req_addr[2] = 32'h0000_0900;
    req_vld = 3'b100;
    @(negedge clk);
    req_vld = '0;
    @(negedge clk);
    chk("mid busy", 32'(mem_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst mem_vld", 32'(mem_vld), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst rsp_vld", 32'(rsp_vld), 32'd0);
    @(negedge clk);
    chk("mid rst rsp_vld2", 32'(rsp_vld), 32'd0);
    req_vld = 3'b011;
    rst_n = 1'b1;
    #1;
    chk("post rst grant", 32'(req_rdy), 32'b001);
    @(negedge clk);
    req_vld = '0;
    mem_rdy = 1'b1;
    mem_rdata = 32'h0000_ABCD;
    @(negedge clk);
    mem_rdy = 1'b0;
    #1;
    chk("post rst rsp_vld", 32'(rsp_vld), 32'b001);
    chk("post rst rdata", rsp_rdata, 32'h0000_ABCD);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
